// File: rtl/sm83_alu_ctl.sv
// sm83_alu_ctl - sequencer for a 4-bit, two-pass SM83-style ALU.
// An 8-bit operation is run as: load A, load B, low nibble, high nibble, done.
// The controller drives the ALU input bus and strobes, captures the low-nibble
// carry (hc) and builds the {Z,N,H,C} flags from the ALU carry/zero outputs.
//
// Configuration macro: SM83_ALU_CTL_CHAIN_EN
//   undefined (default): DONE always returns to IDLE, one request per 6 cycles.
//   defined            : a request may also be accepted in DONE and goes straight
//                        to LOAD_A, giving one request per 5 cycles.
module sm83_alu_ctl (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [2:0] op_i,
    input  logic [7:0] a_val_i,
    input  logic [7:0] b_val_i,
    output logic       ready_o,
    output logic       done_o,
    output logic [7:0] result_o,
    output logic [3:0] flags_o,
    output logic [7:0] alu_din_o,
    output logic       alu_load_a_o,
    output logic       alu_load_b_o,
    output logic       alu_shift_oe_o,
    output logic       alu_result_oe_o,
    output logic       alu_op_low_o,
    output logic       alu_op_b_high_o,
    output logic       alu_negate_o,
    output logic       alu_carry_in_o,
    output logic       alu_no_carry_out_o,
    output logic       alu_force_carry_o,
    output logic       alu_ignore_carry_o,
    input  logic       alu_carry_i,
    input  logic       alu_zero_i,
    input  logic [7:0] alu_dout_i
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_LOW    = 3'd3,
        S_HIGH   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Subtract-class ops run the ALU with B inverted and report inverted carries.
    function automatic logic op_is_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
    endfunction

    // Bitwise ops ignore the nibble carry chain and use fixed flag values.
    function automatic logic op_is_logic(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_XOR) || (op == OP_OR);
    endfunction

    // Carry-in for the low nibble (and for both nibbles of a bitwise op).
    function automatic logic op_const_cin(input logic [2:0] op, input logic c_flag);
        logic cin;
        case (op)
            OP_ADD:  cin = 1'b0;
            OP_ADC:  cin = c_flag;
            OP_SUB:  cin = 1'b1;
            OP_SBC:  cin = ~c_flag;
            OP_AND:  cin = 1'b1;
            OP_XOR:  cin = 1'b0;
            OP_OR:   cin = 1'b0;
            OP_CP:   cin = 1'b1;
            default: cin = 1'b0;
        endcase
        return cin;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       hc_q, hc_d;
    logic [7:0] result_q, result_d;
    logic [3:0] flags_q, flags_d;
    logic       done_q, done_d;

    logic [7:0] din_q, din_d;
    logic       load_a_q, load_a_d;
    logic       load_b_q, load_b_d;
    logic       shift_oe_q, shift_oe_d;
    logic       result_oe_q, result_oe_d;
    logic       op_low_q, op_low_d;
    logic       op_b_high_q, op_b_high_d;
    logic       negate_q, negate_d;
    logic       carry_in_q, carry_in_d;
    logic       no_cout_q, no_cout_d;
    logic       force_c_q, force_c_d;
    logic       ignore_c_q, ignore_c_d;

    logic       ready_state_s;
    logic       accept_s;

    // States in which a new request may be taken.
    always_comb begin
`ifdef SM83_ALU_CTL_CHAIN_EN
        ready_state_s = (state_q == S_IDLE) || (state_q == S_DONE);
`else
        ready_state_s = (state_q == S_IDLE);
`endif
        accept_s = start_i && ready_state_s;
    end

    // Next-state logic for the fixed five-step sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD_A;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_LOW;
            S_LOW:    state_d = S_HIGH;
            S_HIGH:   state_d = S_DONE;
            S_DONE: begin
`ifdef SM83_ALU_CTL_CHAIN_EN
                if (start_i) begin
                    state_d = S_LOAD_A;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture on the accepting edge and low-nibble carry capture.
    always_comb begin
        if (accept_s) begin
            op_d = op_i;
            a_d  = a_val_i;
            b_d  = b_val_i;
        end else begin
            op_d = op_q;
            a_d  = a_q;
            b_d  = b_q;
        end
        if (state_q == S_LOW) begin
            hc_d = alu_carry_i;
        end else begin
            hc_d = hc_q;
        end
    end

    // Result and flag update on the edge leaving HIGH.
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        if (state_q == S_HIGH) begin
            if (op_q != OP_CP) begin
                result_d = alu_dout_i;
            end else begin
                result_d = result_q;
            end
            if (op_is_logic(op_q)) begin
                flags_d = {alu_zero_i, 1'b0, (op_q == OP_AND), 1'b0};
            end else if (op_is_sub(op_q)) begin
                flags_d = {alu_zero_i, 1'b1, ~hc_q, ~alu_carry_i};
            end else begin
                flags_d = {alu_zero_i, 1'b0, hc_q, alu_carry_i};
            end
        end else begin
            result_d = result_q;
            flags_d  = flags_q;
        end
    end

    // ALU bus and strobe decode for the state being entered, so outputs are registered.
    always_comb begin
        din_d       = 8'h00;
        load_a_d    = 1'b0;
        load_b_d    = 1'b0;
        shift_oe_d  = 1'b0;
        result_oe_d = 1'b0;
        op_low_d    = 1'b0;
        op_b_high_d = 1'b0;
        negate_d    = 1'b0;
        carry_in_d  = 1'b0;
        no_cout_d   = 1'b0;
        force_c_d   = 1'b0;
        ignore_c_d  = 1'b0;
        done_d      = (state_d == S_DONE);
        case (state_d)
            S_LOAD_A: begin
                din_d      = a_d;
                shift_oe_d = 1'b1;
                load_a_d   = 1'b1;
            end
            S_LOAD_B: begin
                din_d      = b_d;
                shift_oe_d = 1'b1;
                load_b_d   = 1'b1;
            end
            S_LOW: begin
                op_low_d   = 1'b1;
                negate_d   = op_is_sub(op_d);
                force_c_d  = (op_d == OP_AND);
                no_cout_d  = (op_d == OP_XOR);
                ignore_c_d = (op_d == OP_OR);
                carry_in_d = op_const_cin(op_d, flags_q[0]);
            end
            S_HIGH: begin
                op_b_high_d = 1'b1;
                result_oe_d = 1'b1;
                negate_d    = op_is_sub(op_d);
                force_c_d   = (op_d == OP_AND);
                no_cout_d   = (op_d == OP_XOR);
                ignore_c_d  = (op_d == OP_OR);
                if (op_is_logic(op_d)) begin
                    carry_in_d = op_const_cin(op_d, flags_q[0]);
                end else begin
                    // High nibble continues the chain from the low-nibble carry.
                    carry_in_d = hc_d;
                end
            end
            default: begin
                din_d = 8'h00;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            hc_q        <= 1'b0;
            result_q    <= 8'h00;
            flags_q     <= 4'b0000;
            done_q      <= 1'b0;
            din_q       <= 8'h00;
            load_a_q    <= 1'b0;
            load_b_q    <= 1'b0;
            shift_oe_q  <= 1'b0;
            result_oe_q <= 1'b0;
            op_low_q    <= 1'b0;
            op_b_high_q <= 1'b0;
            negate_q    <= 1'b0;
            carry_in_q  <= 1'b0;
            no_cout_q   <= 1'b0;
            force_c_q   <= 1'b0;
            ignore_c_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hc_q        <= hc_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            done_q      <= done_d;
            din_q       <= din_d;
            load_a_q    <= load_a_d;
            load_b_q    <= load_b_d;
            shift_oe_q  <= shift_oe_d;
            result_oe_q <= result_oe_d;
            op_low_q    <= op_low_d;
            op_b_high_q <= op_b_high_d;
            negate_q    <= negate_d;
            carry_in_q  <= carry_in_d;
            no_cout_q   <= no_cout_d;
            force_c_q   <= force_c_d;
            ignore_c_q  <= ignore_c_d;
        end
    end

    // ready is gated by reset so it is low during reset and high right after release.
    assign ready_o            = ready_state_s && !reset_i;
    assign done_o             = done_q;
    assign result_o           = result_q;
    assign flags_o            = flags_q;
    assign alu_din_o          = din_q;
    assign alu_load_a_o       = load_a_q;
    assign alu_load_b_o       = load_b_q;
    assign alu_shift_oe_o     = shift_oe_q;
    assign alu_result_oe_o    = result_oe_q;
    assign alu_op_low_o       = op_low_q;
    assign alu_op_b_high_o    = op_b_high_q;
    assign alu_negate_o       = negate_q;
    assign alu_carry_in_o     = carry_in_q;
    assign alu_no_carry_out_o = no_cout_q;
    assign alu_force_carry_o  = force_c_q;
    assign alu_ignore_carry_o = ignore_c_q;

endmodule

// File: tb/tb_sm83_alu_ctl.sv
// Self-checking bench for sm83_alu_ctl: a behavioural 4-bit ALU answers the
// controller's strobes, and an 8-bit arithmetic reference model predicts
// result and flags.
module tb_sm83_alu_ctl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [7:0] a_val, b_val;
    logic       ready, done;
    logic [7:0] result;
    logic [3:0] flags;
    logic [7:0] alu_din;
    logic       alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe;
    logic       alu_op_low, alu_op_b_high, alu_negate, alu_carry_in;
    logic       alu_no_carry_out, alu_force_carry, alu_ignore_carry;
    logic       alu_carry, alu_zero;
    logic [7:0] alu_dout;

    int checks;
    int failures;

    logic [7:0] m_res;
    logic [3:0] m_flags;

`ifdef SM83_ALU_CTL_CHAIN_EN
    localparam int EXP_GAP = 5;
`else
    localparam int EXP_GAP = 6;
`endif

    sm83_alu_ctl dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .start_i            (start),
        .op_i               (op),
        .a_val_i            (a_val),
        .b_val_i            (b_val),
        .ready_o            (ready),
        .done_o             (done),
        .result_o           (result),
        .flags_o            (flags),
        .alu_din_o          (alu_din),
        .alu_load_a_o       (alu_load_a),
        .alu_load_b_o       (alu_load_b),
        .alu_shift_oe_o     (alu_shift_oe),
        .alu_result_oe_o    (alu_result_oe),
        .alu_op_low_o       (alu_op_low),
        .alu_op_b_high_o    (alu_op_b_high),
        .alu_negate_o       (alu_negate),
        .alu_carry_in_o     (alu_carry_in),
        .alu_no_carry_out_o (alu_no_carry_out),
        .alu_force_carry_o  (alu_force_carry),
        .alu_ignore_carry_o (alu_ignore_carry),
        .alu_carry_i        (alu_carry),
        .alu_zero_i         (alu_zero),
        .alu_dout_i         (alu_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural nibble ALU driven by the controller's strobes.
    logic [7:0] m_ra, m_rb, bb;
    logic [3:0] m_lo;
    logic [4:0] low_sum, hi_sum;

    always_ff @(posedge clk) begin
        if (alu_load_a) m_ra <= alu_din;
        if (alu_load_b) m_rb <= alu_din;
        if (alu_op_low) m_lo <= low_sum[3:0];
    end

    always_comb begin
        bb        = alu_negate ? ~m_rb : m_rb;
        low_sum   = {1'b0, m_ra[3:0]} + {1'b0, bb[3:0]} + {4'd0, alu_carry_in};
        hi_sum    = {1'b0, m_ra[7:4]} + {1'b0, bb[7:4]} + {4'd0, alu_carry_in};
        alu_dout  = 8'h00;
        alu_carry = 1'b0;
        if (alu_force_carry) begin
            alu_dout  = m_ra & m_rb;
            alu_carry = 1'b1;
        end else if (alu_no_carry_out) begin
            alu_dout  = m_ra ^ m_rb;
        end else if (alu_ignore_carry) begin
            alu_dout  = m_ra | m_rb;
        end else if (alu_op_low) begin
            alu_dout  = {4'h0, low_sum[3:0]};
            alu_carry = low_sum[4];
        end else if (alu_op_b_high) begin
            alu_dout  = {hi_sum[3:0], m_lo};
            alu_carry = hi_sum[4];
        end
        alu_zero = (alu_dout == 8'h00);
    end

    // Reference: SM83 8-bit semantics in plain integer arithmetic.
    task automatic ref_step(input logic [2:0] rop, input logic [7:0] a, input logic [7:0] b);
        int ai, bi, ci, r;
        logic z, n, h, c;
        ai = a; bi = b; ci = 0; r = 0; n = 1'b0; h = 1'b0; c = 1'b0;
        case (rop)
            3'd0, 3'd1: begin
                ci = (rop == 3'd1 && m_flags[0]) ? 1 : 0;
                r  = ai + bi + ci;
                h  = ((ai % 16) + (bi % 16) + ci) > 15;
                c  = r > 255;
                r  = r % 256;
            end
            3'd2, 3'd3, 3'd7: begin
                ci = (rop == 3'd3 && m_flags[0]) ? 1 : 0;
                h  = (ai % 16) < ((bi % 16) + ci);
                c  = ai < (bi + ci);
                r  = (ai - bi - ci + 512) % 256;
                n  = 1'b1;
            end
            3'd4: begin r = ai & bi; h = 1'b1; end
            3'd5: r = ai ^ bi;
            3'd6: r = ai | bi;
            default: r = 0;
        endcase
        z = (r == 0);
        if (rop != 3'd7) m_res = r[7:0];
        m_flags = {z, n, h, c};
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!ready) begin
            failures++;
            $display("FAIL wait_ready: ready=%0b after %0d cycles, required 1", ready, n);
        end
    endtask

    // One full request: accept, latency, result/flags, single-cycle done.
    task automatic do_op(input logic [2:0] rop, input logic [7:0] a, input logic [7:0] b);
        int n;
        wait_ready();
        start = 1'b1; op = rop; a_val = a; b_val = b;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        ref_step(rop, a, b);
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL latency op=%0d: got %0d edges, required 4", rop, n);
        end
        checks++;
        if (result !== m_res) begin
            failures++;
            $display("FAIL result op=%0d a=%h b=%h: got %h, required %h", rop, a, b, result, m_res);
        end
        checks++;
        if (flags !== m_flags) begin
            failures++;
            $display("FAIL flags op=%0d a=%h b=%h: got %b, required %b", rop, a, b, flags, m_flags);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_width op=%0d: done=%b one cycle later, required 0", rop, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'd0; a_val = 8'h00; b_val = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ready, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_hs: ready/done=%b, required 00", {ready, done});
        end
        checks++;
        if ({result, flags} !== 12'h000) begin
            failures++;
            $display("FAIL reset_regs: result=%h flags=%b, required 00/0000", result, flags);
        end
        checks++;
        if ({alu_din, alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe} !== 12'h000) begin
            failures++;
            $display("FAIL reset_strobes: din=%h strobes=%b, required 0",
                     alu_din, {alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe});
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: ready=%b, required 1", ready);
        end
        m_res = 8'h00; m_flags = 4'b0000;
    endtask

    task automatic test_directed();
        do_op(3'd0, 8'h3A, 8'hC6);
        checks++;
        if ({result, flags} !== {8'h00, 4'b1011}) begin
            failures++;
            $display("FAIL add_vector: got %h/%b, required 00/1011", result, flags);
        end
        do_op(3'd1, 8'hFF, 8'h00);
        checks++;
        if ({result, flags} !== {8'h00, 4'b1011}) begin
            failures++;
            $display("FAIL adc_vector: got %h/%b, required 00/1011", result, flags);
        end
        do_op(3'd2, 8'h10, 8'h01);
        do_op(3'd7, 8'h05, 8'h05);
        checks++;
        if ({result, flags} !== {8'h0F, 4'b1100}) begin
            failures++;
            $display("FAIL cp_vector: got %h/%b, required 0F/1100", result, flags);
        end
        do_op(3'd4, 8'hF0, 8'h3C);
        do_op(3'd6, 8'h00, 8'h00);
        do_op(3'd5, 8'hFF, 8'h0F);
    endtask

    task automatic test_strobes();
        logic [7:0] a, b;
        a = 8'($urandom); b = 8'($urandom);
        wait_ready();
        start = 1'b1; op = 3'd2; a_val = a; b_val = b;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe, alu_op_low, alu_op_b_high, alu_din} !== {6'b101000, a}) begin
            failures++;
            $display("FAIL strobe_load_a: got %b din=%h, required 101000 din=%h",
                     {alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe, alu_op_low, alu_op_b_high}, alu_din, a);
        end
        @(posedge clk); #1;
        checks++;
        if ({alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe, alu_op_low, alu_op_b_high, alu_din} !== {6'b011000, b}) begin
            failures++;
            $display("FAIL strobe_load_b: got %b din=%h, required 011000 din=%h",
                     {alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe, alu_op_low, alu_op_b_high}, alu_din, b);
        end
        @(posedge clk); #1;
        checks++;
        if ({alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe, alu_op_low, alu_op_b_high, alu_negate, alu_carry_in} !== 8'b00001011) begin
            failures++;
            $display("FAIL strobe_low: got %b, required 00001011",
                     {alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe, alu_op_low, alu_op_b_high, alu_negate, alu_carry_in});
        end
        @(posedge clk); #1;
        checks++;
        if ({alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe, alu_op_low, alu_op_b_high, alu_negate, alu_carry_in}
            !== {7'b0001011, (a[3:0] >= b[3:0])}) begin
            failures++;
            $display("FAIL strobe_high: got %b, required %b",
                     {alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe, alu_op_low, alu_op_b_high, alu_negate, alu_carry_in},
                     {7'b0001011, (a[3:0] >= b[3:0])});
        end
        @(posedge clk); #1;
        ref_step(3'd2, a, b);
        checks++;
        if ({done, alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe, alu_op_low, alu_op_b_high, result, flags}
            !== {7'b1000000, m_res, m_flags}) begin
            failures++;
            $display("FAIL strobe_done: done=%b result=%h flags=%b, required 1/%h/%b", done, result, flags, m_res, m_flags);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        wait_ready();
        start = 1'b1; op = 3'd0; a_val = 8'h01; b_val = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (alu_op_low !== 1'b1) begin
            failures++;
            $display("FAIL mid_in_low: alu_op_low=%b, required 1", alu_op_low);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({ready, done, result, flags, alu_op_low} !== 15'h0) begin
            failures++;
            $display("FAIL mid_reset_state: ready=%b done=%b result=%h flags=%b low=%b, required all 0",
                     ready, done, result, flags, alu_op_low);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        m_res = 8'h00; m_flags = 4'b0000;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_release_ready: ready=%b, required 1", ready);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++;
        if (seen != 0 || result !== 8'h00 || flags !== 4'b0000) begin
            failures++;
            $display("FAIL mid_no_done: done pulses=%0d result=%h flags=%b, required 0/00/0000", seen, result, flags);
        end
        do_op(3'd0, 8'h01, 8'h01);
    endtask

    task automatic test_start_ignored();
        int seen;
        logic [7:0] a, b;
        a = 8'($urandom); b = 8'($urandom);
        wait_ready();
        start = 1'b1; op = 3'd5; a_val = a; b_val = b;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; op = 3'd6; a_val = 8'($urandom); b_val = 8'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        ref_step(3'd5, a, b);
        checks++;
        if (done !== 1'b1 || result !== m_res || flags !== m_flags) begin
            failures++;
            $display("FAIL ignore_low_start: done=%b result=%h flags=%b, required 1/%h/%b", done, result, flags, m_res, m_flags);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++;
        if (seen != 0 || result !== m_res) begin
            failures++;
            $display("FAIL ignore_low_extra: extra done=%0d result=%h, required 0/%h", seen, result, m_res);
        end
    endtask

    task automatic test_back_to_back();
        int n, gap;
        logic [7:0] a1, b1, a2, b2;
        a1 = 8'($urandom); b1 = 8'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
        wait_ready();
        start = 1'b1; op = 3'd0; a_val = a1; b_val = b1;
        @(posedge clk); #1;
        op = 3'd1; a_val = a2; b_val = b2;
        n = 0;
        while (!done && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        ref_step(3'd0, a1, b1);
        checks++;
        if (n != 4 || result !== m_res || flags !== m_flags) begin
            failures++;
            $display("FAIL b2b_first: latency=%0d result=%h flags=%b, required 4/%h/%b", n, result, flags, m_res, m_flags);
        end
        gap = 0;
        while (gap < 12) begin
            @(posedge clk); #1;
            gap++;
            if (done) break;
        end
        start = 1'b0;
        checks++;
        if (gap != EXP_GAP) begin
            failures++;
            $display("FAIL b2b_gap: got %0d cycles, required %0d", gap, EXP_GAP);
        end
        ref_step(3'd1, a2, b2);
        checks++;
        if (result !== m_res || flags !== m_flags) begin
            failures++;
            $display("FAIL b2b_second: result=%h flags=%b, required %h/%b", result, flags, m_res, m_flags);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done_width: done=%b, required 0", done);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_strobes();
        test_random();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm83_alu_ctl.md
SM83_ALU_CTL -- requirements
Module: sm83_alu_ctl

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 start, op  in  1, 3  request strobe; opcode 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP.
REQ-004 a_val, b_val  in  8, 8  operands, sampled on the accepting edge.
REQ-005 ready, done  out  1, 1  request can be accepted; one-cycle completion pulse.
REQ-006 result, flags  out  8, 4  registered result; flags {Z,N,H,C}.
REQ-007 alu_din  out  8  data driven onto the ALU input bus.
REQ-008 alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe  out  1 each  ALU strobes.
REQ-009 alu_op_low, alu_op_b_high, alu_negate, alu_carry_in  out  1 each  ALU core selects.
REQ-010 alu_no_carry_out, alu_force_carry, alu_ignore_carry  out  1 each  ALU R/S/V signals.
REQ-011 alu_carry, alu_zero, alu_dout  in  1, 1, 8  ALU carry, bus-zero and bus outputs.

Function
REQ-012 States: IDLE, LOAD_A, LOAD_B, LOW, HIGH, DONE.
REQ-013 Each state lasts one cycle except IDLE.
REQ-014 Transition IDLE->LOAD_A occurs on an edge where start=1; op, a_val and b_val are captured on that edge.
REQ-015 Fixed transitions: LOAD_A->LOAD_B->LOW->HIGH->DONE->IDLE.
REQ-016 ready=1 only in IDLE (see REQ-032); start is ignored in every other state.
REQ-017 Latency: request accepted at edge k -> done=1 in the cycle after edge k+4.
REQ-018 In LOAD_A: alu_din=a, alu_shift_oe=1, alu_load_a=1.
REQ-019 In LOAD_B: alu_din=b, alu_shift_oe=1, alu_load_b=1.
REQ-020 Every ALU strobe not explicitly listed for a state SHALL be 0 in that state.
REQ-021 LOW: alu_op_low=1, alu_op_b_high=0; carry-in per op (REQ-023); the edge leaving LOW stores alu_carry as internal hc.
REQ-022 HIGH: alu_op_low=0, alu_op_b_high=1, alu_result_oe=1; carry-in is hc for arithmetic ops and the per-op constant for logic ops.
REQ-023 Per-op ALU control:
 - ADD: carry_in=0.
 - ADC: carry_in=C.
 - SUB and CP: negate=1, carry_in=1.
 - SBC: negate=1, carry_in=!C.
 - AND: force_carry=1, carry_in=1.
 - XOR: no_carry_out=1, carry_in=0.
 - OR: ignore_carry=1, carry_in=0.
REQ-024 The edge leaving HIGH SHALL load result<=alu_dout (except CP, which leaves result unchanged) and Z<=alu_zero.
REQ-025 Flags, arithmetic ops:
 - N=1 for SUB/SBC/CP, else 0.
 - H=hc for add ops, !hc for subtract ops.
 - C=alu_carry for add ops, !alu_carry for subtract ops.
REQ-026 Flags, logic ops: N=0, C=0; H=1 for AND, H=0 for XOR/OR.
REQ-027 done=1 only in DONE; result and flags hold until the next HIGH exit.

Reset
REQ-028 Reset asserted in any state, including mid-operation: state=IDLE, result=0x00, flags=0000, hc=0, all ALU strobes 0, alu_din=0.
REQ-029 While reset is asserted: ready=0 and done=0; ready=1 in the first cycle after deassertion.
REQ-030 An operation interrupted by reset SHALL NOT update result or flags and SHALL NOT pulse done.

Configuration
REQ-031 Macro SM83_ALU_CTL_CHAIN_EN controls back-to-back issue.
REQ-032 With SM83_ALU_CTL_CHAIN_EN defined:
 - ready=1 also in DONE.
 - start in DONE goes directly DONE->LOAD_A, capturing the new operands.
 - The ADC/SBC carry-in uses the C value written on the preceding HIGH exit.
 - Back-to-back issue takes one request per 5 cycles.
REQ-033 Without SM83_ALU_CTL_CHAIN_EN: DONE always returns to IDLE; one request per 6 cycles maximum.

Verification
REQ-034 ADD a=0x3A b=0xC6 -> result 0x00, flags Z1 N0 H1 C1; done exactly 4 edges after accept.
REQ-035 ADC a=0xFF b=0x00 with C=1 -> result 0x00, Z1 N0 H1 C1.
REQ-036 SUB a=0x10 b=0x01 -> result 0x0F, Z0 N1 H1 C0; CP a=0x05 b=0x05 -> result unchanged, Z1 N1 H0 C0.
REQ-037 AND a=0xF0 b=0x3C -> 0x30, Z0 N0 H1 C0; OR a=0x00 b=0x00 -> 0x00, Z1 H0; XOR a=0xFF b=0x0F -> 0xF0.
REQ-038 Reset in LOW during ADD 0x01+0x01 -> IDLE, result 0x00, flags 0000, no done pulse; the next request completes normally.
REQ-039 CHAIN_EN: start held high for two requests -> the second done pulse occurs 5 cycles after the first; start during LOW is ignored in both builds.
